// File: rtl/ocx_tlx_fifo_pkg.sv
// Shared helpers and default geometry for the TLX parametrised FIFO family.
package ocx_tlx_fifo_pkg;

    localparam int TLX_FIFO_WIDTH     = 513;
    localparam int TLX_FIFO_DEPTH     = 32;
    localparam int TLX_FIFO_MIN_DEPTH = 8;
    localparam int PAR_MAX_W          = 2048;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Zero-extension does not change XOR parity, so one wide reducer serves all widths.
    function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ocx_tlx_pfifo_cntlr.sv
// Pointer, occupancy and status control for ocx_tlx_param_fifo; drives RAM strobes and head load.
module ocx_tlx_pfifo_cntlr
    import ocx_tlx_fifo_pkg::*;
#(
    parameter int DEPTH        = TLX_FIFO_DEPTH,
    parameter int MIN_DEPTH    = TLX_FIFO_MIN_DEPTH,
    parameter int AFULL_MARGIN = 2,
    parameter int CW           = clog2(DEPTH + 1),
    parameter int AW           = clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_enable,
    input  logic          rd_done,
    input  logic          use_min_fifo_depth,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    output logic          head_load,
    output logic          data_available,
    output logic          data_look_ahead,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          almost_full,
    output logic          overflow_error,
    output logic          underflow_error
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cap;
    logic [CW-1:0] ram_cnt;
    logic [CW-1:0] count_nxt;
    logic          pop_ok;
    logic          wr_ok;

    assign cap     = use_min_fifo_depth ? CW'(MIN_DEPTH) : CW'(DEPTH);
    assign pop_ok  = rd_done & data_available;
    assign wr_ok   = wr_enable & ((count < cap) | pop_ok);
    // Entries still in the RAM, i.e. not yet moved into the head register.
    assign ram_cnt = count - CW'(data_available);
    assign head_load = (ram_cnt != '0) & (~data_available | pop_ok);

    assign ram_we    = wr_ok;
    assign ram_waddr = wr_ptr;
    assign ram_raddr = rd_ptr;

    always_comb begin
        count_nxt = count;
        case ({wr_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            data_available  <= 1'b0;
            data_look_ahead <= 1'b0;
            full            <= 1'b0;
            almost_full     <= 1'b0;
            overflow_error  <= 1'b0;
            underflow_error <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (head_load)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            if (head_load)
                data_available <= 1'b1;
            else if (pop_ok)
                data_available <= 1'b0;
            data_look_ahead <= (count_nxt >= CW'(2));
            full            <= (count_nxt >= cap);
            almost_full     <= ((int'(count_nxt) + AFULL_MARGIN) >= int'(cap));
            if (wr_enable & ~wr_ok)
                overflow_error <= 1'b1;
            if (rd_done & ~data_available)
                underflow_error <= 1'b1;
        end
    end

endmodule

// File: rtl/ocx_tlx_param_fifo.sv
// First-word-fall-through TLX FIFO: register file plus registered head entry.
// Define OCX_TLX_FIFO_PARITY_EN to store and check even parity per entry.
module ocx_tlx_param_fifo
    import ocx_tlx_fifo_pkg::*;
#(
    parameter int WIDTH        = TLX_FIFO_WIDTH,
    parameter int DEPTH        = TLX_FIFO_DEPTH,
    parameter int MIN_DEPTH    = TLX_FIFO_MIN_DEPTH,
    parameter int AFULL_MARGIN = 2,
    parameter int CW           = clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             wr_enable,
    input  logic             rd_done,
    input  logic             use_min_fifo_depth,
    output logic [WIDTH-1:0] data_out,
    output logic             data_available,
    output logic             data_look_ahead,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             almost_full,
    output logic             overflow_error,
    output logic             underflow_error,
    output logic             parity_error
);

    localparam int AW = clog2(DEPTH);
`ifdef OCX_TLX_FIFO_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic          head_load;
    logic [SW-1:0] wr_entry;
    logic [SW-1:0] rd_entry;
    logic [SW-1:0] mem [DEPTH];

    ocx_tlx_pfifo_cntlr #(
        .DEPTH        (DEPTH),
        .MIN_DEPTH    (MIN_DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN),
        .CW           (CW),
        .AW           (AW)
    ) u_cntlr (
        .clock              (clock),
        .reset              (reset),
        .wr_enable          (wr_enable),
        .rd_done            (rd_done),
        .use_min_fifo_depth (use_min_fifo_depth),
        .ram_we             (ram_we),
        .ram_waddr          (ram_waddr),
        .ram_raddr          (ram_raddr),
        .head_load          (head_load),
        .data_available     (data_available),
        .data_look_ahead    (data_look_ahead),
        .count              (count),
        .full               (full),
        .almost_full        (almost_full),
        .overflow_error     (overflow_error),
        .underflow_error    (underflow_error)
    );

`ifdef OCX_TLX_FIFO_PARITY_EN
    assign wr_entry = {even_par(PAR_MAX_W'(data_in)), data_in};
`else
    assign wr_entry = data_in;
`endif
    assign rd_entry = mem[ram_raddr];

    always_ff @(posedge clock) begin
        if (ram_we)
            mem[ram_waddr] <= wr_entry;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            data_out <= '0;
        else if (head_load)
            data_out <= rd_entry[WIDTH-1:0];
    end

`ifdef OCX_TLX_FIFO_PARITY_EN
    // Data plus stored parity must reduce to zero; anything else is a corrupted entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            parity_error <= 1'b0;
        else if (head_load && even_par(PAR_MAX_W'(rd_entry)))
            parity_error <= 1'b1;
    end
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_ocx_tlx_param_fifo.sv
// Directed bench for ocx_tlx_param_fifo with hand-computed expectations.
module tb_ocx_tlx_param_fifo;

    localparam int W  = 513;
    localparam int CW = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  data_in = '0;
    logic          wr_enable = 1'b0;
    logic          rd_done = 1'b0;
    logic          use_min_fifo_depth = 1'b0;
    logic [W-1:0]  data_out;
    logic          data_available;
    logic          data_look_ahead;
    logic [CW-1:0] count;
    logic          full;
    logic          almost_full;
    logic          overflow_error;
    logic          underflow_error;
    logic          parity_error;

    int checks   = 0;
    int failures = 0;

    ocx_tlx_param_fifo #(
        .WIDTH        (W),
        .DEPTH        (32),
        .MIN_DEPTH    (8),
        .AFULL_MARGIN (2)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .data_in            (data_in),
        .wr_enable          (wr_enable),
        .rd_done            (rd_done),
        .use_min_fifo_depth (use_min_fifo_depth),
        .data_out           (data_out),
        .data_available     (data_available),
        .data_look_ahead    (data_look_ahead),
        .count              (count),
        .full               (full),
        .almost_full        (almost_full),
        .overflow_error     (overflow_error),
        .underflow_error    (underflow_error),
        .parity_error       (parity_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset is asserted between edges so the async clear is observed without a clock.
    task automatic do_reset();
        wr_enable = 1'b0;
        rd_done   = 1'b0;
        use_min_fifo_depth = 1'b0;
        reset = 1'b1;
        #2;
        chk("rst_count", count, 0);
        chk("rst_avail", data_available, 0);
        reset = 1'b0;
        tick();
    endtask

    task automatic push_seq(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_enable = 1'b1;
            data_in   = W'(first + i);
            tick();
        end
        wr_enable = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_count0", count, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_la", data_look_ahead, 0);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_ovf", overflow_error, 0);
        chk("rst_unf", underflow_error, 0);
        chk("rst_par", parity_error, 0);
        tick();

        // Fill to 32 watching almost_full/full thresholds
        for (int i = 1; i <= 32; i++) begin
            wr_enable = 1'b1;
            data_in   = W'(i);
            tick();
            if (i == 29) chk("afull_29", almost_full, 0);
            if (i == 30) chk("afull_30", almost_full, 1);
            if (i == 31) chk("full_31", full, 0);
        end
        chk("full_32", full, 1);
        chk("count_32", count, 32);
        data_in = W'(33);
        tick();
        wr_enable = 1'b0;
        chk("ovf_set", overflow_error, 1);
        chk("ovf_count", count, 32);
        rd_done = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            chk($sformatf("drain32_%0d", i), data_out, W'(i));
            chk($sformatf("drain32_av_%0d", i), data_available, 1);
            tick();
        end
        rd_done = 1'b0;
        chk("drain32_cnt", count, 0);
        chk("drain32_av", data_available, 0);

        // Latency into empty FIFO, then write+pop at count 1
        do_reset();
        wr_enable = 1'b1;
        data_in   = W'(8'hA5);
        tick();
        wr_enable = 1'b0;
        chk("lat_n1_av", data_available, 0);
        tick();
        chk("lat_n2_av", data_available, 1);
        chk("lat_n2_dout", data_out, W'(8'hA5));
        chk("lat_n2_cnt", count, 1);
        wr_enable = 1'b1;
        rd_done   = 1'b1;
        data_in   = W'(8'h3C);
        tick();
        wr_enable = 1'b0;
        rd_done   = 1'b0;
        chk("wp1_n1_av", data_available, 0);
        chk("wp1_n1_cnt", count, 1);
        tick();
        chk("wp1_n2_av", data_available, 1);
        chk("wp1_n2_dout", data_out, W'(8'h3C));

        // Back-to-back pops of 4 entries
        do_reset();
        push_seq(1, 4);
        chk("b2b_cnt4", count, 4);
        rd_done = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("b2b_dout_%0d", i), data_out, W'(i));
            chk($sformatf("b2b_la_%0d", i), data_look_ahead, W'(i <= 3));
            tick();
        end
        rd_done = 1'b0;
        chk("b2b_cnt0", count, 0);
        chk("b2b_av0", data_available, 0);

        // Underflow, then normal traffic still works
        do_reset();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("unf_set", underflow_error, 1);
        chk("unf_cnt", count, 0);
        push_seq(8'h55, 1);
        tick();
        chk("unf_after_dout", data_out, W'(8'h55));
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("unf_after_cnt", count, 0);
        chk("unf_sticky", underflow_error, 1);
        chk("unf_no_ovf", overflow_error, 0);

        // Reduced depth while holding 12 entries
        do_reset();
        push_seq(1, 12);
        chk("min_full_pre", full, 0);
        use_min_fifo_depth = 1'b1;
        tick();
        chk("min_full", full, 1);
        wr_enable = 1'b1;
        data_in   = W'(99);
        tick();
        wr_enable = 1'b0;
        chk("min_ovf", overflow_error, 1);
        chk("min_ovf_cnt", count, 12);
        rd_done = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            chk($sformatf("min_dout_%0d", i), data_out, W'(i));
            tick();
            chk($sformatf("min_full_%0d", i), full, W'((12 - i) >= 8));
            chk($sformatf("min_afull_%0d", i), almost_full, W'((12 - i) >= 6));
        end
        rd_done = 1'b0;
        chk("min_cnt0", count, 0);

`ifdef OCX_TLX_FIFO_PARITY_EN
        // Corrupt the entry at address 3 (value 4) before it reaches the head
        do_reset();
        push_seq(1, 6);
        dut.mem[3] = dut.mem[3] ^ 514'd1;
        rd_done = 1'b1;
        tick();
        tick();
        chk("par_before", parity_error, 0);
        tick();
        chk("par_after", parity_error, 1);
        rd_done = 1'b0;
`else
        chk("par_tied", parity_error, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
